serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
// - Sequencer that time-shares one full_adder cell to add two WIDTH-bit operands bit-serially, LSB first.
// - Accepts one operand pair via a valid/ready handshake, runs WIDTH add cycles through a carry flop,
//   and presents sum and final carry on a valid/ready output handshake.
// - Low-area arithmetic path wherever a full WIDTH-bit ripple adder is not justified.
// PARAMETERS
// - WIDTH   8   operand/sum width in bits; legal range 1..64
// - CNT_W   (WIDTH>1 ? $clog2(WIDTH) : 1)   bit-counter width; derived, not overridden
// PORTS
// - clk        in   1      single clock; all state updates on rising edge
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      operand pair valid
// - in_ready   out  1      controller accepts operands (IDLE only)
// - in_a       in   WIDTH  operand A
// - in_b       in   WIDTH  operand B
// - in_carry   in   1      carry-in for bit 0
// - out_valid  out  1      result valid (DONE only)
// - out_ready  in   1      consumer takes result
// - out_sum    out  WIDTH  A + B + carry_in, modulo 2^WIDTH
// - out_carry  out  1      carry out of bit WIDTH-1
// - busy       out  1      high in RUN and DONE
// BEHAVIOUR
// - Reset (async assert, sync deassert by system): state=IDLE; in_ready=1 after reset release; out_valid=0,
//   out_sum=0, out_carry=0, busy=0; operand shift regs, carry flop, bit counter all cleared.
// - FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready edge: load a_sr=in_a, b_sr=in_b, c_q=in_carry, cnt=0 -> RUN.
//   RUN: each edge feeds a_sr[0], b_sr[0], c_q to full_adder; sum bit shifted into res_sr MSB
//        (res_sr shifts right); a_sr/b_sr shift right; c_q <= adder carry; cnt++.
//        Edge with cnt==WIDTH-1 is the last bit -> DONE.
//   DONE: out_valid=1; out_sum=res_sr, out_carry=c_q held stable until out_valid&&out_ready edge -> IDLE.
// - Latency: out_valid rises exactly WIDTH cycles after the accepting edge. Issue interval WIDTH+2 cycles
//   with out_ready held high (accept, WIDTH run cycles, DONE cycle, then IDLE).
// - in_ready is 0 in RUN and DONE; no same-cycle bypass from DONE to a new accept.
// - Input changes on in_a/in_b/in_carry/in_valid during RUN/DONE are ignored (operands registered).
// - out_sum/out_carry are registered; outside DONE they keep the last result (0 after reset); only
//   out_valid qualifies them.
// - WIDTH=1: RUN lasts one cycle; cnt compare holds at 0.
// - Reset asserted mid-RUN or mid-DONE: transaction discarded, no out_valid pulse, all regs to reset values.
// - No overflow flag beyond out_carry; signed interpretation is the consumer's responsibility.
// STRUCTURE
// - One instance of existing full_adder (in_x=a_sr[0], in_y=b_sr[0], carry_in=c_q).
// - Shared package serial_arith_pkg: state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2),
//   default WIDTH constant; reused by future serial multiplier/subtractor sequencers.
// - No further sub-modules; FSM, counter and shift regs live in this module.
// TESTING (WIDTH=8 unless stated; model = {carry,sum} = A+B+Cin)
// - Reset: rst_n low 3 cycles -> in_ready=1 after release, out_valid=0, out_sum=0x00, busy=0.
// - Basic: A=0x12, B=0x34, Cin=0 accepted at edge E -> out_valid at E+8, sum=0x46, carry=0.
// - Full carry chain: A=0xFF, B=0x01, Cin=0 -> sum=0x00, carry=1; A=0x5A, B=0xA5, Cin=1 -> sum=0x00, carry=1.
// - Backpressure: out_ready low 5 cycles in DONE -> out_valid, out_sum, out_carry stable, in_ready=0;
//   in_valid toggling and in_a changes during RUN do not alter result.
// - Reset mid-RUN after 3 bits -> outputs to reset values, no out_valid; next A=0x80, B=0x80 -> sum=0x00, carry=1.
// - Streaming + sweep: in_valid/out_ready held high, 1000 random pairs -> one result per 10 cycles, all
//   match model; repeat with WIDTH=1 exhaustive (8 cases).

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic sequencers.
package serial_arith_pkg;

  // Sequencer state encoding, common to all serial arithmetic controllers
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared by the serial sequencers.
module full_adder (
  input  logic in_x,
  input  logic in_y,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  // Plain combinational sum/carry
  always_comb begin
    sum       = in_x ^ in_y ^ carry_in;
    carry_out = (in_x & in_y) | (carry_in & (in_x ^ in_y));
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell time-shared over WIDTH cycles, LSB first.
module serial_adder_ctrl
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum, fa_carry;
  logic             last_bit;

  full_adder u_full_adder (
    .in_x      (a_sr[0]),
    .in_y      (b_sr[0]),
    .carry_in  (c_q),
    .sum       (fa_sum),
    .carry_out (fa_carry)
  );

  // Result shift: new sum bit enters at the MSB (shift-right form also covers WIDTH=1)
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = fa_sum;
    last_bit            = (cnt == LAST_BIT);
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand load, serial datapath and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (state_q == ST_IDLE && in_valid) begin
      a_sr <= in_a;
      b_sr <= in_b;
      c_q  <= in_carry;
      cnt  <= '0;
    end else if (state_q == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      c_q    <= fa_carry;
      res_sr <= res_next;
      cnt    <= cnt + CNT_W'(1);
      // Separate output copy so out_sum/out_carry hold the last result outside DONE
      if (last_bit) begin
        sum_q   <= res_next;
        carry_q <= fa_carry;
      end
    end
  end

  assign out_sum   = sum_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // WIDTH=8 instance signals
  logic       in_valid = 1'b0, in_carry = 1'b0, out_ready = 1'b1;
  logic [7:0] in_a = '0, in_b = '0;
  logic       in_ready, out_valid, out_carry, busy;
  logic [7:0] out_sum;

  // WIDTH=1 instance signals
  logic       w1_in_valid = 1'b0, w1_in_carry = 1'b0, w1_out_ready = 1'b1;
  logic [0:0] w1_in_a = '0, w1_in_b = '0;
  logic       w1_in_ready, w1_out_valid, w1_out_carry, w1_busy;
  logic [0:0] w1_out_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_res = 0;
  logic ov_prev = 1'b0;

  logic [8:0] sb[$];
  int         lat_q[$];
  logic [1:0] sb1[$];

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .in_a      (w1_in_a),
    .in_b      (w1_in_b),
    .in_carry  (w1_in_carry),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .out_sum   (w1_out_sum),
    .out_carry (w1_out_carry),
    .busy      (w1_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Scoreboard monitor for the WIDTH=8 instance: push on accept, pop on result handshake
  always @(negedge clk) begin
    logic [8:0] e;
    int lat;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(9'(in_a) + 9'(in_b) + 9'(in_carry));
        lat_q.push_back(cyc + 1);
      end
      if (out_valid && !ov_prev) begin
        checks++;
        if (lat_q.size() == 0) begin
          errors++;
          $display("FAIL latency: out_valid rose with no pending accept at cycle %0d", cyc);
        end else begin
          lat = lat_q.pop_front();
          if (cyc - lat !== 8) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 8", cyc - lat);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL result: unexpected result %h/%b with empty scoreboard", out_sum, out_carry);
        end else begin
          e = sb.pop_front();
          n_res++;
          if ({out_carry, out_sum} !== e) begin
            errors++;
            $display("FAIL result: got carry=%b sum=%h, required carry=%b sum=%h",
                     out_carry, out_sum, e[8], e[7:0]);
          end
        end
      end
      ov_prev <= out_valid;
    end else begin
      ov_prev <= 1'b0;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_carry = c; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !busy) break;
    end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain: pending=%0d busy=%b, required 0 and 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_sum, out_carry, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_w8: rdy=%b vld=%b sum=%h c=%b busy=%b, required 1 0 00 0 0",
               in_ready, out_valid, out_sum, out_carry, busy);
    end
    checks++;
    if ({w1_in_ready, w1_out_valid, w1_out_sum, w1_out_carry, w1_busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_w1: rdy=%b vld=%b sum=%b c=%b busy=%b, required 1 0 0 0 0",
               w1_in_ready, w1_out_valid, w1_out_sum, w1_out_carry, w1_busy);
    end
  endtask

  task automatic test_basic();
    send(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_run: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'h46 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: vld=%b sum=%h c=%b, required 1 46 0", out_valid, out_sum, out_carry);
    end
    drain();
  endtask

  task automatic test_carry_chain();
    send(8'hFF, 8'h01, 1'b0);
    drain();
    checks++;
    if (out_sum !== 8'h00 || out_carry !== 1'b1) begin
      errors++;
      $display("FAIL chain_ff01: sum=%h c=%b, required 00 1", out_sum, out_carry);
    end
    send(8'h5A, 8'hA5, 1'b1);
    drain();
    checks++;
    if (out_sum !== 8'h00 || out_carry !== 1'b1) begin
      errors++;
      $display("FAIL chain_5aa5: sum=%h c=%b, required 00 1", out_sum, out_carry);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1 out_ready = 1'b0;
    send(8'hC8, 8'h4B, 1'b1);  // 0xC8+0x4B+1 = 0x114
    // Junk on the inputs while running must not disturb the registered operands
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      in_carry = ~in_carry;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({out_valid, out_sum, out_carry, in_ready, busy} !== {1'b1, 8'h14, 1'b1, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL backpressure[%0d]: vld=%b sum=%h c=%b rdy=%b busy=%b, required 1 14 1 0 1",
                 k, out_valid, out_sum, out_carry, in_ready, busy);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid_run();
    send(8'h77, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    lat_q.delete();
    #1;
    checks++;
    if ({in_ready, out_valid, out_sum, out_carry, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset: rdy=%b vld=%b sum=%h c=%b busy=%b, required 1 0 00 0 0",
               in_ready, out_valid, out_sum, out_carry, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrun_quiet[%0d]: vld=%b busy=%b, required 0 0", k, out_valid, busy);
      end
    end
    send(8'h80, 8'h80, 1'b0);
    drain();
    checks++;
    if (out_sum !== 8'h00 || out_carry !== 1'b1) begin
      errors++;
      $display("FAIL midrun_next: sum=%h c=%b, required 00 1", out_sum, out_carry);
    end
  endtask

  task automatic test_stream();
    int cnt = 0;
    int first_acc = 0;
    int last_acc = 0;
    int res0 = n_res;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_a = 8'($urandom); in_b = 8'($urandom); in_carry = 1'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 20000 && cnt < 1000; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (cnt == 0) first_acc = cyc;
        last_acc = cyc;
        cnt++;
        @(posedge clk); #1;
        if (cnt == 1000) in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom); in_carry = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (n_res - res0 !== 1000) begin
      errors++;
      $display("FAIL stream_count: got %0d results, required 1000", n_res - res0);
    end
    checks++;
    if (last_acc - first_acc !== 999 * 10) begin
      errors++;
      $display("FAIL stream_rate: span %0d cycles, required %0d", last_acc - first_acc, 999 * 10);
    end
  endtask

  task automatic test_width1();
    logic [1:0] e;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(posedge clk); #1;
      w1_in_a = v[2]; w1_in_b = v[1]; w1_in_carry = v[0]; w1_in_valid = 1'b1;
      sb1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (w1_in_ready) break;
      end
      @(posedge clk); #1;
      w1_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (w1_out_valid !== 1'b0 || w1_busy !== 1'b1) begin
        errors++;
        $display("FAIL w1_run[%0d]: vld=%b busy=%b, required 0 1", i, w1_out_valid, w1_busy);
      end
      @(negedge clk);
      e = sb1.pop_front();
      checks++;
      if (w1_out_valid !== 1'b1 || {w1_out_carry, w1_out_sum} !== e) begin
        errors++;
        $display("FAIL w1_sum[%0d]: vld=%b c=%b s=%b, required 1 %b %b",
                 i, w1_out_valid, w1_out_carry, w1_out_sum, e[1], e[0]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_reset_mid_run();
    test_stream();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
